multicycle_control_unit: RTL and testbench

Multi-cycle successor to the single-cycle opcode decoder. It sequences each RV32I instruction through IF/ID/EX/MEM/WB states and emits per-state datapath controls. It handles variable-latency memory through a ready handshake with a wait timeout, halts on ECALL or an illegal opcode, and counts retired instructions. It sits between the instruction register (opcode source) and the multi-cycle datapath and memory.

---
 rtl/multicycle_control_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control sequencer: walks IF/ID/EX/MEM/WB, drives datapath
// controls per state, bounds memory waits, halts on ECALL/illegal, counts retires.
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             ecall_halt_req,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             pc_update,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic             mem_timeout,
    output logic             illegal_inst,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired_cnt
);

    localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_mem_timeout;
    logic               r_illegal;
    logic [CNT_W-1:0]   r_retired;

    logic       w_ir_write, w_i_or_d, w_mem_read, w_mem_write;
    logic       w_reg_write, w_mem_to_reg, w_pc_to_reg, w_alu_src_a;
    logic [1:0] w_alu_src_b, w_alu_op, w_pc_src;
    logic       w_pc_update;
    logic       w_timeout_set, w_illegal_set;
    logic       w_legal, w_wait_expire;

    always_comb begin
        unique case (opcode)
            OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: w_legal = 1'b1;
            default:                              w_legal = 1'b0;
        endcase
    end

    // The wait that would bring the counter to MEM_WAIT_MAX is the last one
    // tolerated; mem_ready in that same cycle still completes the access.
    assign w_wait_expire = (r_wait == WAIT_W'(MEM_WAIT_MAX - 1)) && !mem_ready;

    always_comb begin
        w_ir_write    = 1'b0;
        w_i_or_d      = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_pc_to_reg   = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = 2'd0;
        w_alu_op      = 2'd0;
        w_pc_update   = 1'b0;
        w_pc_src      = 2'd0;
        w_timeout_set = 1'b0;
        w_illegal_set = 1'b0;
        w_next        = r_state;

        case (r_state)
            S_IF: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_next     = S_ID;
                end else if (w_wait_expire) begin
                    w_timeout_set = 1'b1;
                    w_next        = S_HALT;
                end
            end

            S_ID: begin
                // Speculative branch/jump target: ALUOut <= PC + imm
                w_alu_src_b = 2'd2;
                if (!w_legal) begin
                    w_illegal_set = 1'b1;
                    w_next        = S_HALT;
                end else if (opcode == OP_ECALL) begin
                    if (ecall_halt_req) begin
                        w_next = S_HALT;
                    end else begin
                        w_pc_update = 1'b1;
                        w_next      = S_IF;
                    end
                end else if (opcode == OP_JAL) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_EX;
                end
            end

            S_EX: begin
                w_alu_src_a = 1'b1;
                case (opcode)
                    OP_ARITH: begin
                        w_alu_op = 2'd1;
                        w_next   = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        w_alu_src_b = 2'd2;
                        w_alu_op    = 2'd1;
                        w_next      = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        w_alu_src_b = 2'd2;
                        w_next      = S_MEM;
                    end
                    OP_JALR: begin
                        w_alu_src_b = 2'd2;
                        w_next      = S_WB;
                    end
                    OP_BRANCH: begin
                        w_alu_op    = 2'd2;
                        w_pc_update = 1'b1;
                        w_pc_src    = 2'd3;
                        w_next      = S_IF;
                    end
                    default: w_next = S_IF;
                endcase
            end

            S_MEM: begin
                w_i_or_d    = 1'b1;
                w_mem_read  = (opcode == OP_LOAD);
                w_mem_write = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_STORE) begin
                        w_pc_update = 1'b1;
                        w_next      = S_IF;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_expire) begin
                    w_timeout_set = 1'b1;
                    w_next        = S_HALT;
                end
            end

            S_WB: begin
                w_reg_write  = 1'b1;
                w_pc_update  = 1'b1;
                w_mem_to_reg = (opcode == OP_LOAD);
                w_pc_to_reg  = (opcode == OP_JAL) || (opcode == OP_JALR);
                if (opcode == OP_JAL)
                    w_pc_src = 2'd1;
                else if (opcode == OP_JALR)
                    w_pc_src = 2'd2;
                w_next = S_IF;
            end

            S_HALT: w_next = S_HALT;

            default: w_next = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IF;
            r_wait        <= '0;
            r_mem_timeout <= 1'b0;
            r_illegal     <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, which covers entry to IF/MEM
            if (w_next != r_state)
                r_wait <= '0;
            else if ((r_state == S_IF || r_state == S_MEM) && !mem_ready)
                r_wait <= r_wait + WAIT_W'(1);
            if (w_timeout_set)
                r_mem_timeout <= 1'b1;
            if (w_illegal_set)
                r_illegal <= 1'b1;
            if (w_pc_update)
                r_retired <= r_retired + CNT_W'(1);
        end
    end

    // Gating with reset_n drops every enable the instant reset asserts.
    assign ir_write     = reset_n & w_ir_write;
    assign i_or_d       = reset_n & w_i_or_d;
    assign mem_read     = reset_n & w_mem_read;
    assign mem_write    = reset_n & w_mem_write;
    assign reg_write    = reset_n & w_reg_write;
    assign mem_to_reg   = reset_n & w_mem_to_reg;
    assign pc_to_reg    = reset_n & w_pc_to_reg;
    assign alu_src_a    = reset_n & w_alu_src_a;
    assign alu_src_b    = {2{reset_n}} & w_alu_src_b;
    assign alu_op       = {2{reset_n}} & w_alu_op;
    assign pc_update    = reset_n & w_pc_update;
    assign pc_src       = {2{reset_n}} & w_pc_src;
    assign halted       = (r_state == S_HALT);
    assign mem_timeout  = r_mem_timeout;
    assign illegal_inst = r_illegal;
    assign state        = r_state;
    assign retired_cnt  = r_retired;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: CPI table, per-cycle control checks from an
// instruction-path model, randomized instruction stream, timeout/halt/reset corners.
module tb_multicycle_control_unit;

    localparam int MAXW = 15;
    localparam int CW   = 4;   // narrow counter so the random stream exercises wrap

    localparam logic [6:0] OP_AR   = 7'b0110011;
    localparam logic [6:0] OP_AI   = 7'b0010011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_EC   = 7'b1110011;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic          mem_ready = 1'b0;
    logic          ecall_halt_req = 1'b0;
    logic          ir_write, i_or_d, mem_read, mem_write, reg_write;
    logic          mem_to_reg, pc_to_reg, alu_src_a, pc_update;
    logic [1:0]    alu_src_b, alu_op, pc_src;
    logic          halted, mem_timeout, illegal_inst;
    logic [2:0]    state;
    logic [CW-1:0] retired_cnt;

    multicycle_control_unit #(.MEM_WAIT_MAX(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
        .ecall_halt_req(ecall_halt_req), .ir_write(ir_write), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_update(pc_update),
        .pc_src(pc_src), .halted(halted), .mem_timeout(mem_timeout),
        .illegal_inst(illegal_inst), .state(state), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    logic [17:0] obs;
    assign obs = {state, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
                  pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_update, pc_src};

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ret = 0;

    typedef struct {
        int   ph;
        logic rdy;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        int         cpi;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected controls for a phase (0=IF..4=WB) of an instruction; ECALL assumed non-halting.
    function automatic logic [17:0] exp_vec(input int ph, input logic [6:0] op, input logic rdy);
        logic irw, iod, mr, mw, rw, m2r, p2r, a, pcu;
        logic [1:0] b, aop, ps;
        irw = 0; iod = 0; mr = 0; mw = 0; rw = 0; m2r = 0; p2r = 0; a = 0; pcu = 0;
        b = 0; aop = 0; ps = 0;
        case (ph)
            0: begin mr = 1; irw = rdy; end
            1: begin b = 2; pcu = (op == OP_EC); end
            2: begin
                a = 1;
                if (op == OP_AR) aop = 1;
                if (op == OP_AI) begin b = 2; aop = 1; end
                if (op == OP_LD || op == OP_ST || op == OP_JALR) b = 2;
                if (op == OP_BR) begin aop = 2; pcu = 1; ps = 3; end
            end
            3: begin
                iod = 1; mr = (op == OP_LD); mw = (op == OP_ST);
                pcu = (op == OP_ST) && rdy;
            end
            4: begin
                rw = 1; pcu = 1; m2r = (op == OP_LD);
                p2r = (op == OP_JAL) || (op == OP_JALR);
                ps = (op == OP_JAL) ? 2'd1 : (op == OP_JALR) ? 2'd2 : 2'd0;
            end
            default: ;
        endcase
        return {3'(ph), irw, iod, mr, mw, rw, m2r, p2r, a, b, aop, pcu, ps};
    endfunction

    // Enter at a negedge with the DUT in IF; leave at the negedge the next IF begins.
    task automatic run_instr(input logic [6:0] op, input int wif, input int wmem);
        int   ph[$];
        cyc_t q[$];
        cyc_t c;
        int   w;
        ph.push_back(0);
        ph.push_back(1);
        case (op)
            OP_AR, OP_AI, OP_JALR: begin ph.push_back(2); ph.push_back(4); end
            OP_LD:  begin ph.push_back(2); ph.push_back(3); ph.push_back(4); end
            OP_ST:  begin ph.push_back(2); ph.push_back(3); end
            OP_BR:  ph.push_back(2);
            OP_JAL: ph.push_back(4);
            default: ;
        endcase
        foreach (ph[k]) begin
            c.ph = ph[k];
            if (ph[k] == 0 || ph[k] == 3) begin
                w = (ph[k] == 0) ? wif : wmem;
                for (int j = 0; j < w; j++) begin
                    c.rdy = 1'b0;
                    q.push_back(c);
                end
                c.rdy = 1'b1;
                q.push_back(c);
            end else begin
                c.rdy = 1'($urandom_range(0, 1));
                q.push_back(c);
            end
        end
        foreach (q[k]) begin
            mem_ready      = q[k].rdy;
            opcode         = (q[k].ph == 0) ? 7'($urandom) : op;
            ecall_halt_req = (q[k].ph == 1 && op == OP_EC) ? 1'b0 : 1'($urandom_range(0, 1));
            #2;
            chk($sformatf("ctrl op=%b cyc=%0d", op, k), 32'(obs), 32'(exp_vec(q[k].ph, op, q[k].rdy)));
            @(negedge clk);
        end
        exp_ret = (exp_ret + 1) % (1 << CW);
        chk($sformatf("retired op=%b", op), 32'(retired_cnt), 32'(exp_ret));
    endtask

    // Leaves the DUT freshly out of reset at a negedge, in its first IF cycle.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        exp_ret = 0;
    endtask

    task automatic drive(input logic rdy, input logic [6:0] op, input logic hreq);
        mem_ready = rdy;
        opcode = op;
        ecall_halt_req = hreq;
        #2;
    endtask

    vec_t tbl[8];
    logic [6:0] rops[8];

    initial begin
        int n;
        int r0;
        logic [6:0] op;

        tbl[0] = '{OP_AR, 4};   tbl[1] = '{OP_AI, 4};
        tbl[2] = '{OP_LD, 5};   tbl[3] = '{OP_ST, 4};
        tbl[4] = '{OP_BR, 3};   tbl[5] = '{OP_JAL, 3};
        tbl[6] = '{OP_JALR, 4}; tbl[7] = '{OP_EC, 2};
        rops[0] = OP_AR; rops[1] = OP_AI; rops[2] = OP_LD; rops[3] = OP_ST;
        rops[4] = OP_BR; rops[5] = OP_JAL; rops[6] = OP_JALR; rops[7] = OP_EC;

        // Reset holds every control at zero
        reset_n = 1'b0; opcode = OP_AR; mem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("reset_ctrl", 32'(obs), 32'd0);
        chk("reset_cnt", 32'(retired_cnt), 32'd0);
        chk("reset_flags", {29'd0, halted, mem_timeout, illegal_inst}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ret = 0;

        // First instruction: ARITH walks 0,1,2,4 then back to IF
        run_instr(OP_AR, 0, 0);

        // Zero-wait cycles per instruction
        for (int i = 0; i < 8; i++) begin
            n = 0;
            r0 = 32'(retired_cnt);
            mem_ready = 1'b1; ecall_halt_req = 1'b0; opcode = tbl[i].op;
            do begin
                @(negedge clk);
                n++;
            end while (state != 3'd0 && n < 50);
            chk($sformatf("cpi op=%b", tbl[i].op), 32'(n), 32'(tbl[i].cpi));
            chk($sformatf("cpi_ret op=%b", tbl[i].op), 32'((32'(retired_cnt) - r0) & ((1 << CW) - 1)), 32'd1);
            exp_ret = (exp_ret + 1) % (1 << CW);
        end

        // LOAD with two MEM wait cycles: seven cycles total
        run_instr(OP_LD, 0, 2);

        // BRANCH, JAL, JALR back to back
        r0 = 32'(retired_cnt);
        run_instr(OP_BR, 0, 0);
        run_instr(OP_JAL, 0, 0);
        run_instr(OP_JALR, 0, 0);
        chk("b2b_ret", 32'((32'(retired_cnt) - r0) & ((1 << CW) - 1)), 32'd3);

        // Randomized stream against the instruction-path model
        for (int i = 0; i < 40; i++) begin
            op = rops[$urandom_range(0, 7)];
            run_instr(op, ($urandom_range(0, 7) == 0) ? MAXW - 1 : int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0) ? MAXW - 1 : int'($urandom_range(0, 3)));
        end
        chk("no_timeout", {31'd0, mem_timeout}, 32'd0);

        // IF starved for MEM_WAIT_MAX cycles -> timeout halt
        do_reset();
        for (int i = 0; i < MAXW; i++) begin
            drive(1'b0, 7'($urandom), 1'b0);
            if (i == 0 || i == MAXW - 1)
                chk($sformatf("if_wait%0d", i), 32'(obs), 32'(exp_vec(0, OP_AR, 1'b0)));
            @(negedge clk);
        end
        drive(1'b1, OP_AR, 1'b0);
        chk("if_to_halt", 32'(obs), {14'd0, 3'd5, 15'd0});
        chk("if_to_flags", {29'd0, halted, mem_timeout, illegal_inst}, 32'b110);
        repeat (3) @(negedge clk);
        #2;
        chk("halt_absorb", {28'd0, state, halted}, {28'd0, 3'd5, 1'b1});
        chk("halt_ret", 32'(retired_cnt), 32'd0);

        // Ready on the last tolerated cycle completes normally
        do_reset();
        run_instr(OP_AR, MAXW - 1, 0);
        chk("edge_no_timeout", {31'd0, mem_timeout}, 32'd0);

        // LOAD starved in MEM -> timeout halt
        do_reset();
        drive(1'b1, OP_LD, 1'b0); @(negedge clk);
        drive(1'b1, OP_LD, 1'b0); @(negedge clk);
        drive(1'b1, OP_LD, 1'b0); @(negedge clk);
        for (int i = 0; i < MAXW; i++) begin
            drive(1'b0, OP_LD, 1'b0);
            @(negedge clk);
        end
        #2;
        chk("mem_to_halt", {28'd0, state, mem_timeout}, {28'd0, 3'd5, 1'b1});

        // ECALL with halt request
        do_reset();
        drive(1'b1, OP_AR, 1'b0); @(negedge clk);
        drive(1'b1, OP_EC, 1'b1);
        chk("ecall_id_nopc", {31'd0, pc_update}, 32'd0);
        @(negedge clk);
        #2;
        chk("ecall_halt", {28'd0, state, halted}, {28'd0, 3'd5, 1'b1});
        repeat (2) @(negedge clk);
        #2;
        chk("ecall_sticky", {31'd0, halted}, 32'd1);
        chk("ecall_ret", 32'(retired_cnt), 32'd0);

        // Illegal opcode
        do_reset();
        drive(1'b1, OP_AR, 1'b0); @(negedge clk);
        drive(1'b1, 7'b1111111, 1'b0);
        @(negedge clk);
        #2;
        chk("illegal", {28'd0, state, illegal_inst}, {28'd0, 3'd5, 1'b1});

        // Reset asserted in the middle of a STORE's MEM wait
        do_reset();
        drive(1'b1, OP_ST, 1'b0); @(negedge clk);
        drive(1'b1, OP_ST, 1'b0); @(negedge clk);
        drive(1'b1, OP_ST, 1'b0); @(negedge clk);
        drive(1'b0, OP_ST, 1'b0);
        chk("st_mem_write", {28'd0, state, mem_write}, {28'd0, 3'd3, 1'b1});
        #1 reset_n = 1'b0;
        #1;
        chk("st_async_drop", {28'd0, state, mem_write}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        exp_ret = 0;
        chk("st_rst_cnt", 32'(retired_cnt), 32'd0);
        run_instr(OP_ST, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
